calc_entry_fsm: RTL and testbench

// Operand-entry sequencer for the calculator datapath. Collects hex digit keys and

---
 rtl/calc_entry_fsm.sv | 145 ++++++++++++++
 tb/tb_calc_entry_fsm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_fsm.sv
// Operand-entry sequencer for the calculator: builds N1/N2 from hex digit keys,
// latches the add/sub selection and issues a one-cycle enable on '='.
module calc_entry_fsm #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   key_val,
  input  logic         key_valid,
  input  logic         key_add,
  input  logic         key_sub,
  input  logic         key_eq,
  input  logic         key_clr,
  output logic [W-1:0] N1,
  output logic [W-1:0] N2,
  output logic         soma,
  output logic         sub,
  output logic         enable,
  output logic [W-1:0] disp,
  output logic [1:0]   state
);

  localparam int ND = W / 4;
  localparam int CW = $clog2(ND + 1);

  typedef enum logic [1:0] {
    S_N1  = 2'd0,
    S_N2  = 2'd1,
    S_RES = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   n1_reg, n1_next;
  logic [W-1:0]   n2_reg, n2_next;
  logic [W-1:0]   disp_reg, disp_next;
  logic [CW-1:0]  c1_reg, c1_next;
  logic [CW-1:0]  c2_reg, c2_next;
  logic           soma_reg, soma_next;
  logic           sub_reg, sub_next;
  logic           enable_reg, enable_next;
  logic           clear_all;

  // Clear key and the unused state code both collapse to the reset values.
  assign clear_all = key_clr || (state_reg == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_N1;
      n1_reg     <= '0;
      n2_reg     <= '0;
      disp_reg   <= '0;
      c1_reg     <= '0;
      c2_reg     <= '0;
      soma_reg   <= 1'b0;
      sub_reg    <= 1'b0;
      enable_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      n1_reg     <= n1_next;
      n2_reg     <= n2_next;
      disp_reg   <= disp_next;
      c1_reg     <= c1_next;
      c2_reg     <= c2_next;
      soma_reg   <= soma_next;
      sub_reg    <= sub_next;
      enable_reg <= enable_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    n1_next     = n1_reg;
    n2_next     = n2_reg;
    c1_next     = c1_reg;
    c2_next     = c2_reg;
    soma_next   = soma_reg;
    sub_next    = sub_reg;
    enable_next = 1'b0;
    if (clear_all) begin
      state_next = S_N1;
      n1_next    = '0;
      n2_next    = '0;
      c1_next    = '0;
      c2_next    = '0;
      soma_next  = 1'b0;
      sub_next   = 1'b0;
    end else begin
      case (state_reg)
        S_N1: begin
          if (key_eq) begin
            state_next = S_N1;
          end else if (key_add || key_sub) begin
            soma_next  = key_add;
            sub_next   = !key_add;
            state_next = S_N2;
          end else if (key_valid && (c1_reg != CW'(ND))) begin
            n1_next = {n1_reg[W-5:0], key_val};
            c1_next = c1_reg + CW'(1);
          end
        end
        S_N2: begin
          if (key_eq) begin
            if (c2_reg != '0) begin
              state_next  = S_RES;
              enable_next = 1'b1;
            end
          end else if (key_add || key_sub) begin
            // Operator may only be changed before the second operand starts.
            if (c2_reg == '0) begin
              soma_next = key_add;
              sub_next  = !key_add;
            end
          end else if (key_valid && (c2_reg != CW'(ND))) begin
            n2_next = {n2_reg[W-5:0], key_val};
            c2_next = c2_reg + CW'(1);
          end
        end
        S_RES: begin
          if (!key_eq && !key_add && !key_sub && key_valid) begin
            n1_next    = W'(key_val);
            c1_next    = CW'(1);
            n2_next    = '0;
            c2_next    = '0;
            soma_next  = 1'b0;
            sub_next   = 1'b0;
            state_next = S_N1;
          end
        end
        default: begin
          state_next = S_N1;
        end
      endcase
    end
    disp_next = (state_next == S_N1) ? n1_next : n2_next;
  end

  assign N1     = n1_reg;
  assign N2     = n2_reg;
  assign soma   = soma_reg;
  assign sub    = sub_reg;
  assign enable = enable_reg;
  assign disp   = disp_reg;
  assign state  = state_reg;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Self-checking bench for calc_entry_fsm: directed key sequences plus randomized
// key streams compared against an operand/phase-level reference model.
module tb_calc_entry_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_val;
  logic       key_valid, key_add, key_sub, key_eq, key_clr;
  logic [7:0] N1, N2, disp;
  logic       soma, sub, enable;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  // Reference model: operand values, digit counts, operator (0 none, 1 add, 2 sub),
  // phase (0 typing N1, 1 typing N2, 2 result issued) and expected issue pulse.
  int m_n1, m_n2, m_c1, m_c2, m_op, m_ph, m_en;

  calc_entry_fsm #(.W(8)) dut (
    .clk(clk), .rst(rst), .key_val(key_val), .key_valid(key_valid),
    .key_add(key_add), .key_sub(key_sub), .key_eq(key_eq), .key_clr(key_clr),
    .N1(N1), .N2(N2), .soma(soma), .sub(sub), .enable(enable),
    .disp(disp), .state(state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_n1 = 0; m_n2 = 0; m_c1 = 0; m_c2 = 0; m_op = 0; m_ph = 0; m_en = 0;
  endtask

  // Drive one key event for one cycle, then update the model after the edge.
  task automatic step(input bit c, input bit e, input bit a, input bit s,
                      input bit v, input logic [3:0] d);
    @(negedge clk);
    key_clr = c; key_eq = e; key_add = a; key_sub = s; key_valid = v; key_val = d;
    @(posedge clk);
    #1;
    key_clr = 0; key_eq = 0; key_add = 0; key_sub = 0; key_valid = 0; key_val = 0;
    m_en = 0;
    if (c) begin
      model_reset();
    end else if (e) begin
      if (m_ph == 1 && m_c2 > 0) begin
        m_ph = 2; m_en = 1;
      end
    end else if (a || s) begin
      if (m_ph == 0 || (m_ph == 1 && m_c2 == 0)) begin
        m_op = a ? 1 : 2; m_ph = 1;
      end
    end else if (v) begin
      if (m_ph == 0 && m_c1 < 2) begin
        m_n1 = (m_n1 * 16 + int'(d)) % 256; m_c1++;
      end else if (m_ph == 1 && m_c2 < 2) begin
        m_n2 = (m_n2 * 16 + int'(d)) % 256; m_c2++;
      end else if (m_ph == 2) begin
        m_n1 = int'(d); m_c1 = 1; m_n2 = 0; m_c2 = 0; m_op = 0; m_ph = 0;
      end
    end
    $display("key clr=%0d eq=%0d add=%0d sub=%0d dig=%0d val=%h -> N1=%h N2=%h soma=%0d sub=%0d en=%0d disp=%h st=%0d",
             c, e, a, s, v, d, N1, N2, soma, sub, enable, disp, state);
  endtask

  task automatic digit(input logic [3:0] d); step(0, 0, 0, 0, 1, d); endtask
  task automatic op_add(); step(0, 0, 1, 0, 0, 4'h0); endtask
  task automatic op_sub(); step(0, 0, 0, 1, 0, 4'h0); endtask
  task automatic equals(); step(0, 1, 0, 0, 0, 4'h0); endtask
  task automatic idle();   step(0, 0, 0, 0, 0, 4'h0); endtask
  task automatic clear();  step(1, 0, 0, 0, 0, 4'h0); endtask

  task automatic test_reset();
    checks++; if (N1 !== 8'h00) begin failures++; $display("FAIL reset_n1 got=%h exp=00", N1); end
    checks++; if (N2 !== 8'h00) begin failures++; $display("FAIL reset_n2 got=%h exp=00", N2); end
    checks++; if (disp !== 8'h00) begin failures++; $display("FAIL reset_disp got=%h exp=00", disp); end
    checks++; if ({soma, sub, enable} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {soma, sub, enable}); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
  endtask

  task automatic test_add_sequence();
    clear();
    digit(4'h3); digit(4'h5); op_add(); digit(4'h1); digit(4'h2);
    checks++; if (disp !== 8'h12) begin failures++; $display("FAIL add_disp got=%h exp=12", disp); end
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL add_en_early got=%b exp=0", enable); end
    equals();
    checks++; if (N1 !== 8'h35) begin failures++; $display("FAIL add_n1 got=%h exp=35", N1); end
    checks++; if (N2 !== 8'h12) begin failures++; $display("FAIL add_n2 got=%h exp=12", N2); end
    checks++; if ({soma, sub} !== 2'b10) begin failures++; $display("FAIL add_op got=%b exp=10", {soma, sub}); end
    checks++; if (enable !== 1'b1) begin failures++; $display("FAIL add_en got=%b exp=1", enable); end
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL add_state got=%0d exp=2", state); end
    idle();
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL add_en_drop got=%b exp=0", enable); end
  endtask

  task automatic test_sub_then_new();
    clear();
    digit(4'h9); op_sub(); digit(4'h4); equals();
    checks++; if (N1 !== 8'h09 || N2 !== 8'h04) begin failures++; $display("FAIL sub_ops got=%h/%h exp=09/04", N1, N2); end
    checks++; if ({soma, sub, enable} !== 3'b011) begin failures++; $display("FAIL sub_flags got=%b exp=011", {soma, sub, enable}); end
    digit(4'h7);
    checks++; if (N1 !== 8'h07 || N2 !== 8'h00) begin failures++; $display("FAIL new_ops got=%h/%h exp=07/00", N1, N2); end
    checks++; if (state !== 2'd0 || disp !== 8'h07) begin failures++; $display("FAIL new_state got=%0d/%h exp=0/07", state, disp); end
    checks++; if ({soma, sub} !== 2'b00) begin failures++; $display("FAIL new_op got=%b exp=00", {soma, sub}); end
  endtask

  task automatic test_digit_limit();
    clear();
    digit(4'h1); digit(4'h2); digit(4'h3);
    checks++; if (N1 !== 8'h12) begin failures++; $display("FAIL limit_n1 got=%h exp=12", N1); end
    op_add(); equals();
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL empty_eq_en got=%b exp=0", enable); end
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL empty_eq_state got=%0d exp=1", state); end
  endtask

  task automatic test_priority();
    clear();
    digit(4'h1); op_add();
    step(1, 0, 0, 0, 1, 4'h8);
    checks++; if (N1 !== 8'h00 || disp !== 8'h00) begin failures++; $display("FAIL clr_digit got=%h/%h exp=00/00", N1, disp); end
    checks++; if (state !== 2'd0 || {soma, sub} !== 2'b00) begin failures++; $display("FAIL clr_state got=%0d/%b exp=0/00", state, {soma, sub}); end
    digit(4'h4); op_sub(); digit(4'h5);
    step(0, 1, 1, 0, 0, 4'h0);
    checks++; if (enable !== 1'b1 || state !== 2'd2) begin failures++; $display("FAIL eq_add_issue got=%b/%0d exp=1/2", enable, state); end
    checks++; if ({soma, sub} !== 2'b01) begin failures++; $display("FAIL eq_add_op got=%b exp=01", {soma, sub}); end
  endtask

  task automatic test_op_replace_and_reissue();
    clear();
    op_add(); op_sub();
    checks++; if ({soma, sub} !== 2'b01) begin failures++; $display("FAIL replace_op got=%b exp=01", {soma, sub}); end
    digit(4'h3); op_add();
    checks++; if ({soma, sub} !== 2'b01) begin failures++; $display("FAIL locked_op got=%b exp=01", {soma, sub}); end
    equals();
    checks++; if (enable !== 1'b1) begin failures++; $display("FAIL reissue_first got=%b exp=1", enable); end
    equals();
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL reissue_second got=%b exp=0", enable); end
    equals();
    checks++; if (enable !== 1'b0 || state !== 2'd2) begin failures++; $display("FAIL reissue_third got=%b/%0d exp=0/2", enable, state); end
  endtask

  task automatic test_reset_midentry();
    clear();
    digit(4'h3); op_add(); digit(4'h5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({N1, N2, disp} !== 24'h0 || {soma, sub, enable} !== 3'b000 || state !== 2'd0) begin
      failures++; $display("FAIL async_reset got=%h/%h/%h/%b/%0d exp=all zero", N1, N2, disp, {soma, sub, enable}, state); end
    @(posedge clk);
    #1;
    checks++; if ({N1, N2, disp} !== 24'h0 || state !== 2'd0) begin
      failures++; $display("FAIL reset_hold got=%h/%h/%h/%0d exp=all zero", N1, N2, disp, state); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    digit(4'h6); digit(4'hA); digit(4'hB);
    checks++; if (N1 !== 8'h6A) begin failures++; $display("FAIL post_reset_n1 got=%h exp=6a", N1); end
  endtask

  task automatic test_random();
    logic prev_en = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
      checks++;
      if (N1 !== 8'(m_n1) || N2 !== 8'(m_n2)) begin
        failures++; $display("FAIL rand_ops[%0d] got=%h/%h exp=%h/%h", i, N1, N2, 8'(m_n1), 8'(m_n2)); end
      checks++;
      if (soma !== (m_op == 1) || sub !== (m_op == 2)) begin
        failures++; $display("FAIL rand_op[%0d] got=%b%b exp=%b%b", i, soma, sub, m_op == 1, m_op == 2); end
      checks++;
      if (enable !== (m_en == 1) || (prev_en && enable)) begin
        failures++; $display("FAIL rand_en[%0d] got=%b exp=%0d prev=%b", i, enable, m_en, prev_en); end
      checks++;
      if (state !== 2'(m_ph) || disp !== ((m_ph == 0) ? 8'(m_n1) : 8'(m_n2))) begin
        failures++; $display("FAIL rand_state[%0d] got=%0d/%h exp=%0d", i, state, disp, m_ph); end
      prev_en = enable;
    end
  endtask

  initial begin
    rst = 1'b1;
    key_val = 0; key_valid = 0; key_add = 0; key_sub = 0; key_eq = 0; key_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_add_sequence();
    test_sub_then_new();
    test_digit_limit();
    test_priority();
    test_op_replace_and_reissue();
    test_reset_midentry();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
